// File: rtl/delay_align_controller_if.sv
// Handshake and data bundle between the delay-align controller and its environment.
// DELAY_ALIGN_STEP_DEBUG_EN adds the per-step debug signals (step_valid/step_delay/step_sad).
interface delay_align_controller_if #(
    parameter int DATA_BITS   = 32,
    parameter int DELAY_BITS  = 4,
    parameter int WINDOW_BITS = 6,
    parameter int ACC_BITS    = DATA_BITS + 1 + WINDOW_BITS
);
    logic                         ce;
    logic                         start;
    logic                         abort;
    logic signed [DATA_BITS-1:0]  ref_value;
    logic signed [DATA_BITS-1:0]  dly_value;
    logic [DELAY_BITS-1:0]        delay;
    logic                         busy;
    logic                         done;
    logic                         locked;
    logic [DELAY_BITS-1:0]        best_delay;
    logic [ACC_BITS-1:0]          best_sad;
`ifdef DELAY_ALIGN_STEP_DEBUG_EN
    logic                         step_valid;
    logic [DELAY_BITS-1:0]        step_delay;
    logic [ACC_BITS-1:0]          step_sad;
`endif

`ifdef DELAY_ALIGN_STEP_DEBUG_EN
    modport master (
        output ce, start, abort, ref_value, dly_value,
        input  delay, busy, done, locked, best_delay, best_sad,
        input  step_valid, step_delay, step_sad
    );

    modport slave (
        input  ce, start, abort, ref_value, dly_value,
        output delay, busy, done, locked, best_delay, best_sad,
        output step_valid, step_delay, step_sad
    );
`else
    modport master (
        output ce, start, abort, ref_value, dly_value,
        input  delay, busy, done, locked, best_delay, best_sad
    );

    modport slave (
        input  ce, start, abort, ref_value, dly_value,
        output delay, busy, done, locked, best_delay, best_sad
    );
`endif
endinterface

// File: rtl/delay_align_controller.sv
// Sweep-and-lock controller: scans every delay setting, accumulates SAD per setting, locks at the minimum.
// Optional per-step debug outputs are enabled by defining DELAY_ALIGN_STEP_DEBUG_EN.
module delay_align_controller #(
    parameter int DATA_BITS   = 32,
    parameter int DELAY_BITS  = 4,
    parameter int WINDOW_BITS = 6,
    parameter int ACC_BITS    = DATA_BITS + 1 + WINDOW_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    delay_align_controller_if.slave  bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETTLE  = 3'd1;
    localparam logic [2:0] ACCUM   = 3'd2;
    localparam logic [2:0] COMPARE = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    localparam int SET_BITS = DELAY_BITS + 2;

    // First step waits for the whole line to fill; later steps only flush the line's output register.
    localparam logic [SET_BITS-1:0]    FILL_COUNT  = SET_BITS'((1 << DELAY_BITS) + 2);
    localparam logic [SET_BITS-1:0]    STEP_COUNT  = SET_BITS'(2);
    localparam logic [DELAY_BITS-1:0]  DELAY_MAX   = {DELAY_BITS{1'b1}};
    localparam logic [WINDOW_BITS-1:0] WIN_LAST    = {WINDOW_BITS{1'b1}};

    logic [2:0]              state;
    logic [2:0]              state_next;
    logic [SET_BITS-1:0]     settle_cnt;
    logic [WINDOW_BITS-1:0]  win_cnt;
    logic [ACC_BITS-1:0]     acc;
    logic                    first_step;

    logic [DELAY_BITS-1:0]   delay_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    locked_q;
    logic [DELAY_BITS-1:0]   best_delay_q;
    logic [ACC_BITS-1:0]     best_sad_q;

    logic                    abort_hit;
    logic                    start_ok;
    logic                    settle_done;
    logic                    sample_en;
    logic                    window_done;
    logic                    compare_en;
    logic                    take_best;
    logic                    last_step;
    logic                    finish_en;

    logic signed [DATA_BITS:0] diff;
    logic [DATA_BITS:0]        diff_mag;

    // Difference at DATA_BITS+1 so opposite full-scale samples never wrap.
    always_comb begin
        diff     = {bus.ref_value[DATA_BITS-1], bus.ref_value}
                 - {bus.dly_value[DATA_BITS-1], bus.dly_value};
        diff_mag = diff[DATA_BITS] ? $unsigned(-diff) : $unsigned(diff);
    end

    always_comb begin
        abort_hit   = (state != IDLE) && bus.abort;
        start_ok    = (state == IDLE) && bus.start && !bus.abort;
        settle_done = (state == SETTLE) && !bus.abort && bus.ce && (settle_cnt <= SET_BITS'(1));
        sample_en   = (state == ACCUM) && !bus.abort && bus.ce;
        window_done = sample_en && (win_cnt == WIN_LAST);
        compare_en  = (state == COMPARE) && !bus.abort;
        take_best   = compare_en && (first_step || (acc < best_sad_q));
        last_step   = (delay_q == DELAY_MAX);
        finish_en   = (state == FINISH) && !bus.abort;
    end

    // Abort wins over every transition, including a pending START.
    always_comb begin
        state_next = state;
        if (abort_hit) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok)    state_next = SETTLE;
                SETTLE:  if (settle_done) state_next = ACCUM;
                ACCUM:   if (window_done) state_next = COMPARE;
                COMPARE: state_next = last_step ? FINISH : SETTLE;
                FINISH:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt <= '0;
        end else if (start_ok) begin
            settle_cnt <= FILL_COUNT;
        end else if (compare_en && !last_step) begin
            settle_cnt <= STEP_COUNT;
        end else if ((state == SETTLE) && !bus.abort && bus.ce && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SET_BITS'(1);
        end
    end

    // Accumulator is frozen whenever CE is low, so a stalled window still sees exactly 2**WINDOW_BITS samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            win_cnt <= '0;
        end else if (settle_done) begin
            acc     <= '0;
            win_cnt <= '0;
        end else if (sample_en) begin
            acc <= acc + ACC_BITS'(diff_mag);
            if (!window_done) begin
                win_cnt <= win_cnt + WINDOW_BITS'(1);
            end
        end
    end

    // Strict less-than keeps the lowest delay among equal SADs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_delay_q <= '0;
            best_sad_q   <= '0;
            first_step   <= 1'b0;
        end else if (start_ok) begin
            first_step <= 1'b1;
        end else if (take_best) begin
            best_delay_q <= delay_q;
            best_sad_q   <= acc;
            first_step   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_q  <= '0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= finish_en;
            if (start_ok || abort_hit) begin
                delay_q  <= '0;
                busy_q   <= start_ok;
                locked_q <= 1'b0;
            end else if (compare_en && !last_step) begin
                delay_q <= delay_q + DELAY_BITS'(1);
            end else if (finish_en) begin
                delay_q  <= best_delay_q;
                busy_q   <= 1'b0;
                locked_q <= 1'b1;
            end
        end
    end

`ifdef DELAY_ALIGN_STEP_DEBUG_EN
    logic                   step_valid_q;
    logic [DELAY_BITS-1:0]  step_delay_q;
    logic [ACC_BITS-1:0]    step_sad_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_valid_q <= 1'b0;
            step_delay_q <= '0;
            step_sad_q   <= '0;
        end else begin
            step_valid_q <= compare_en;
            if (compare_en) begin
                step_delay_q <= delay_q;
                step_sad_q   <= acc;
            end
        end
    end

    assign bus.step_valid = step_valid_q;
    assign bus.step_delay = step_delay_q;
    assign bus.step_sad   = step_sad_q;
`endif

    assign bus.delay      = delay_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.locked     = locked_q;
    assign bus.best_delay = best_delay_q;
    assign bus.best_sad   = best_sad_q;

endmodule
